arbiter_rr: RTL and testbench

Parametrised round-robin output arbiter for a NoC router output port. It selects one of `NUM_PORTS` input requesters and drives a one-hot crossbar select. It handshakes flits to the downstream hop with `rts`/`dcts` and holds the grant for a whole packet (wormhole lock). An optional `MAX_HOLD` limit forces re-arbitration after that many transferred flits when other ports are waiting.

---
 rtl/arbiter_rr.sv | 134 +++++++++++++
 tb/tb_arbiter_rr.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr.sv
// rtl/arbiter_rr.sv - round-robin NoC output arbiter with wormhole lock and optional hold limit
module arbiter_rr #(
  parameter int NUM_PORTS = 5,
  parameter int MAX_HOLD  = 0,
  parameter int IDX_W     = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 dcts,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 rts
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  localparam bit             HOLD_EN   = (MAX_HOLD > 0);
  localparam logic [7:0]     HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [7:0]             hold_cnt_q, hold_cnt_d;

  logic                   owner_req;
  logic                   xfer;
  logic                   do_grant;
  logic [NUM_PORTS-1:0]   cand;
  logic [NUM_PORTS-1:0]   others;
  logic [IDX_W-1:0]       win;

  // First set bit of vec scanning upward from start, wrapping at the last port.
  // Iterating downward lets the lowest offset from start overwrite the result.
  function automatic logic [IDX_W-1:0] find_winner(input logic [NUM_PORTS-1:0] vec,
                                                    input logic [IDX_W-1:0]     start);
    logic [IDX_W-1:0] w;
    int               pos;
    w = start;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      pos = int'(start) + i;
      if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
      if (vec[pos]) w = pos[IDX_W-1:0];
    end
    return w;
  endfunction

  // Grant is one-hot, so masking req with it picks out the owner's request.
  always_comb begin
    owner_req = |(req & grant_q);
    rts       = (state_q == S_GRANT) && owner_req;
    xfer      = rts && dcts;
    others    = req & ~grant_q;
  end

  // Next-state: pick a candidate vector, then apply a common new-grant update.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    do_grant    = 1'b0;
    cand        = req;
    win         = '0;

    case (state_q)
      S_IDLE: begin
        if (|req) do_grant = 1'b1;
      end
      S_GRANT: begin
        if (!owner_req) begin
          if (|req) begin
            do_grant = 1'b1;
          end else begin
            state_d     = S_IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
          end
        end else if (HOLD_EN && xfer && (hold_cnt_q == HOLD_LAST)) begin
          if (|others) begin
            do_grant = 1'b1;
            cand     = others;
          end else begin
            hold_cnt_d = 8'd0;
          end
        end else if (HOLD_EN && xfer) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_grant) begin
      win          = find_winner(cand, ptr_q);
      state_d      = S_GRANT;
      grant_d      = '0;
      grant_d[win] = 1'b1;
      grant_idx_d  = win;
      ptr_d        = (win == LAST_IDX) ? '0 : win + 1'b1;
      hold_cnt_d   = 8'd0;
    end
  end

  // State registers with synchronous reset overriding every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign xbar_sel  = grant_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// tb/tb_arbiter_rr.sv - self-checking bench for arbiter_rr with a behavioural reference model
module tb_arbiter_rr;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst0 = 1'b1, rst1 = 1'b1;
  logic [4:0] req0 = '0, req1 = '0;
  logic       dcts0 = 1'b0, dcts1 = 1'b0;
  logic [4:0] grant0, grant1, xsel0, xsel1;
  logic [2:0] idx0, idx1;
  logic       rts0, rts1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: owner port (-1 when idle), round-robin start, hold count.
  int m_owner[2];
  int m_ptr[2];
  int m_cnt[2];
  bit m_valid[2];

  always #5 clk = ~clk;

  arbiter_rr #(.NUM_PORTS(5), .MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst(rst0), .req(req0), .dcts(dcts0),
    .grant(grant0), .xbar_sel(xsel0), .grant_idx(idx0), .rts(rts0)
  );

  arbiter_rr #(.NUM_PORTS(5), .MAX_HOLD(4)) u_dut1 (
    .clk(clk), .rst(rst1), .req(req1), .dcts(dcts1),
    .grant(grant1), .xbar_sel(xsel1), .grant_idx(idx1), .rts(rts1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int winner(input logic [4:0] vec, input int start);
    for (int i = 0; i < N; i++) begin
      if (vec[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  function automatic void model_next(input int owner, input int ptr, input int cnt,
                                     input logic r, input logic [4:0] rq, input logic dc,
                                     input int mh,
                                     output int no, output int np, output int nc);
    int  w;
    bit  rts_m;
    logic [4:0] masked;
    no = owner; np = ptr; nc = cnt; w = -1;
    if (r) begin
      no = -1; np = 0; nc = 0;
      return;
    end
    if (owner < 0) begin
      if (rq != 0) w = winner(rq, ptr);
    end else begin
      rts_m = rq[owner];
      if (!rts_m) begin
        if (rq != 0) w = winner(rq, ptr);
        else no = -1;
      end else if (mh > 0 && dc && cnt == mh - 1) begin
        masked = rq & ~(5'b1 << owner);
        if (masked != 0) w = winner(masked, ptr);
        else nc = 0;
      end else if (dc) begin
        nc = cnt + 1;
      end
    end
    if (w >= 0) begin
      no = w; np = (w + 1) % N; nc = 0;
    end
  endfunction

  // Advance the model on each rising edge from the inputs sampled there.
  always @(posedge clk) begin
    int no, np, nc;
    for (int k = 0; k < 2; k++) begin
      model_next(m_owner[k], m_ptr[k], m_cnt[k],
                 k ? rst1 : rst0, k ? req1 : req0, k ? dcts1 : dcts0, k ? 4 : 0,
                 no, np, nc);
      m_owner[k] <= no;
      m_ptr[k]   <= np;
      m_cnt[k]   <= nc;
      if (k ? rst1 : rst0) m_valid[k] <= 1'b1;
    end
  end

  // Compare every DUT output against the model each cycle, after inputs settle.
  always @(negedge clk) begin
    logic [4:0] eg, ag, ax, rq;
    logic [2:0] ei, ai;
    logic       er, ar;
    #2;
    for (int k = 0; k < 2; k++) begin
      if (m_valid[k]) begin
        rq = k ? req1 : req0;
        eg = (m_owner[k] < 0) ? 5'b0 : (5'b1 << m_owner[k]);
        ei = (m_owner[k] < 0) ? 3'd0 : 3'(m_owner[k]);
        er = (m_owner[k] >= 0) && rq[m_owner[k]];
        ag = k ? grant1 : grant0;
        ax = k ? xsel1 : xsel0;
        ai = k ? idx1 : idx0;
        ar = k ? rts1 : rts0;
        chk(k ? "model_grant1" : "model_grant0", 32'(ag), 32'(eg));
        chk(k ? "model_xsel1" : "model_xsel0", 32'(ax), 32'(eg));
        chk(k ? "model_idx1" : "model_idx0", 32'(ai), 32'(ei));
        chk(k ? "model_rts1" : "model_rts0", 32'(ar), 32'(er));
      end
    end
  end

  task automatic step_in(input int k, input logic r, input logic [4:0] q, input logic d);
    @(negedge clk);
    #1;
    if (k == 0) begin rst0 = r; req0 = q; dcts0 = d; end
    else        begin rst1 = r; req1 = q; dcts1 = d; end
  endtask

  initial begin
    int         order[$];
    int         o;
    logic [3:0] dpat;
    logic [4:0] rq0, rq1;
    m_owner[0] = -1; m_owner[1] = -1;
    m_ptr[0] = 0; m_ptr[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;

    // Reset and single request
    step_in(0, 1'b1, 5'b0, 1'b0);
    step_in(0, 1'b1, 5'b0, 1'b0);
    #1;
    chk("reset_grant", 32'(grant0), 32'h0);
    chk("reset_idx", 32'(idx0), 32'h0);
    chk("reset_rts", 32'(rts0), 32'h0);
    step_in(0, 1'b0, 5'b00100, 1'b1);
    step_in(0, 1'b0, 5'b00100, 1'b1);
    #1;
    chk("single_grant", 32'(grant0), 32'h04);
    chk("single_xsel", 32'(xsel0), 32'h04);
    chk("single_idx", 32'(idx0), 32'd2);
    chk("single_rts", 32'(rts0), 32'd1);

    // Round-robin fairness, each owner releases after 3 transfers
    step_in(0, 1'b1, 5'b0, 1'b0);
    step_in(0, 1'b0, 5'b11111, 1'b1);
    for (int n = 0; n < 6; n++) begin
      o = 0;
      for (int t = 0; t < 3; t++) begin
        step_in(0, 1'b0, 5'b11111, 1'b1);
        #1;
        if (t == 0) begin
          order.push_back(int'(idx0));
          o = int'(idx0);
          chk("fair_no_bubble", 32'(grant0 != 0), 32'd1);
        end
      end
      step_in(0, 1'b0, 5'b11111 & ~(5'b1 << o), 1'b1);
    end
    for (int n = 0; n < 6; n++) chk("fair_order", 32'(order[n]), 32'(n % 5));

    // Wormhole lock with backpressure on port 4
    step_in(0, 1'b1, 5'b0, 1'b0);
    step_in(0, 1'b0, 5'b10000, 1'b1);
    dpat = 4'b1001;
    for (int i = 0; i < 20; i++) begin
      step_in(0, 1'b0, 5'b11111, dpat[3 - (i % 4)]);
      #1;
      chk("lock_grant", 32'(grant0), 32'h10);
      chk("lock_rts", 32'(rts0), 32'd1);
    end
    step_in(0, 1'b0, 5'b01111, 1'b1);

    // Mid-packet reset on port 3
    step_in(0, 1'b1, 5'b0, 1'b0);
    step_in(0, 1'b0, 5'b01000, 1'b1);
    step_in(0, 1'b0, 5'b01000, 1'b1);
    step_in(0, 1'b0, 5'b01000, 1'b1);
    step_in(0, 1'b1, 5'b01000, 1'b1);
    step_in(0, 1'b0, 5'b01000, 1'b1);
    #1;
    chk("midrst_grant", 32'(grant0), 32'h0);
    chk("midrst_rts", 32'(rts0), 32'h0);
    step_in(0, 1'b0, 5'b01000, 1'b1);
    #1;
    chk("midrst_regrant", 32'(grant0), 32'h08);
    chk("midrst_idx", 32'(idx0), 32'd3);

    // Release to idle, then ptr=2 decides between ports 0 and 1
    step_in(0, 1'b1, 5'b0, 1'b0);
    step_in(0, 1'b0, 5'b00010, 1'b1);
    step_in(0, 1'b0, 5'b00010, 1'b1);
    step_in(0, 1'b0, 5'b00000, 1'b1);
    #1;
    chk("release_rts", 32'(rts0), 32'h0);
    step_in(0, 1'b0, 5'b00000, 1'b1);
    #1;
    chk("release_grant", 32'(grant0), 32'h0);
    step_in(0, 1'b0, 5'b00011, 1'b1);
    step_in(0, 1'b0, 5'b00011, 1'b1);
    #1;
    chk("release_next_idx", 32'(idx0), 32'd0);

    // Forced rotation with MAX_HOLD=4
    step_in(1, 1'b1, 5'b0, 1'b0);
    step_in(1, 1'b0, 5'b00011, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step_in(1, 1'b0, 5'b00011, 1'b1);
      #1;
      chk("rot_hold_port0", 32'(grant1), 32'h01);
    end
    step_in(1, 1'b0, 5'b00011, 1'b1);
    #1;
    chk("rot_switch_port1", 32'(grant1), 32'h02);
    step_in(1, 1'b0, 5'b00001, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step_in(1, 1'b0, 5'b00001, 1'b1);
      #1;
      chk("rot_sole_keep", 32'(grant1), 32'h01);
    end

    // Randomised traffic on both instances, model compare runs every cycle
    rq0 = '0; rq1 = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) rq0[b] = ~rq0[b];
        if ($urandom_range(7) == 0) rq1[b] = ~rq1[b];
      end
      @(negedge clk);
      #1;
      rst0 = ($urandom_range(199) == 0);
      rst1 = ($urandom_range(199) == 0);
      req0 = rq0; req1 = rq1;
      dcts0 = 1'($urandom_range(1));
      dcts1 = 1'($urandom_range(1));
    end

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
